// File: rtl/i2c_bit_if.sv
// Command handshake and open-drain pin bundle between the codec init sequencer
// and the I2C bit engine; the engine takes the slave side of the handshake.
interface i2c_bit_if;
  logic [1:0] cmd;
  logic       stb;
  logic [7:0] data_in;
  logic       ack_in;
  logic [7:0] data_out;
  logic       ack_out;
  logic       ready;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_i;

  modport master (
    output cmd, stb, data_in, ack_in, sda_i,
    input  data_out, ack_out, ready, scl_oe, sda_oe
  );

  modport slave (
    input  cmd, stb, data_in, ack_in, sda_i,
    output data_out, ack_out, ready, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_bit_engine.sv
// Byte-level I2C master: START/STOP/WRITE/READ commands become quarter-bit
// sequenced open-drain enables for SCL and SDA, all outputs registered.
module i2c_bit_engine #(
  parameter int DW = 4
) (
  input  logic     clk,
  input  logic     rst,
  i2c_bit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STOP,
    S_WRITE,
    S_READ
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div;
  logic [1:0]    phase, phase_nxt;
  logic [3:0]    bit_cnt, bit_nxt;
  logic          ready_q;

  logic          accept;
  logic          phase_end;
  logic          cmd_end;
  logic          enter;
  logic          sample;

  logic [7:0]    tx_sh;
  logic          ack_r;
  logic [2:0]    tx_idx;
  logic          tx_bit;

  logic          scl_q, sda_q;
  logic          scl_nxt, sda_nxt;
  logic [7:0]    rx_q;
  logic          ack_q;

  assign accept    = bus.stb && ready_q;
  assign phase_end = (state != S_IDLE) && (div == '1);
  assign cmd_end   = phase_end && (phase == 2'd3) &&
                     ((state == S_START) || (state == S_STOP) || (bit_cnt == 4'd8));
  assign sample    = phase_end && (phase == 2'd2) &&
                     ((state == S_WRITE) || (state == S_READ));

  // State register: control only, divider free-runs only while a command is active
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      phase   <= 2'd0;
      bit_cnt <= 4'd0;
      div     <= '0;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      bit_cnt <= bit_nxt;
      ready_q <= (state_nxt == S_IDLE);
      if (accept || (state == S_IDLE))
        div <= '0;
      else
        div <= div + DW'(1);
    end
  end

  // Next-state: accept a command, step quarter-bit phases, or finish
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    bit_nxt   = bit_cnt;
    enter     = 1'b0;
    if (accept) begin
      enter     = 1'b1;
      phase_nxt = 2'd0;
      bit_nxt   = 4'd0;
      case (bus.cmd)
        2'b00:   state_nxt = S_START;
        2'b01:   state_nxt = S_STOP;
        2'b10:   state_nxt = S_WRITE;
        default: state_nxt = S_READ;
      endcase
    end else if (cmd_end) begin
      state_nxt = S_IDLE;
      phase_nxt = 2'd0;
      bit_nxt   = 4'd0;
    end else if (phase_end) begin
      enter     = 1'b1;
      phase_nxt = phase + 2'd1;
      if (phase == 2'd3)
        bit_nxt = bit_cnt + 4'd1;
    end
  end

  // The transmit bit for the phase being entered; on accept the shift register
  // is not loaded yet, so the MSB comes straight from the command bus.
  assign tx_idx = 3'd7 - bit_nxt[2:0];
  assign tx_bit = accept ? bus.data_in[7] : tx_sh[tx_idx];

  // Output logic: line levels applied on entry to each phase, held otherwise
  always_comb begin
    scl_nxt = scl_q;
    sda_nxt = sda_q;
    if (enter) begin
      case (state_nxt)
        S_START: begin
          case (phase_nxt)
            2'd0:    sda_nxt = 1'b0;
            2'd1:    scl_nxt = 1'b0;
            2'd2:    sda_nxt = 1'b1;
            default: scl_nxt = 1'b1;
          endcase
        end
        S_STOP: begin
          case (phase_nxt)
            2'd0:    sda_nxt = 1'b1;
            2'd1:    scl_nxt = 1'b0;
            2'd2:    sda_nxt = 1'b0;
            default: ;
          endcase
        end
        S_WRITE, S_READ: begin
          case (phase_nxt)
            2'd0: begin
              if (bit_nxt[3])
                sda_nxt = (state_nxt == S_READ) ? ~ack_r : 1'b0;
              else
                sda_nxt = (state_nxt == S_WRITE) ? ~tx_bit : 1'b0;
            end
            2'd1:    scl_nxt = 1'b0;
            2'd2:    ;
            default: scl_nxt = 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Output registers: pin enables and the SDA capture taken at the end of P2
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 1'b0;
      sda_q <= 1'b0;
      rx_q  <= 8'h00;
      ack_q <= 1'b0;
    end else begin
      scl_q <= scl_nxt;
      sda_q <= sda_nxt;
      if (sample) begin
        if (!bit_cnt[3])
          rx_q <= {rx_q[6:0], bus.sda_i};
        else if (state == S_WRITE)
          ack_q <= bus.sda_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      tx_sh <= bus.data_in;
      ack_r <= bus.ack_in;
    end
  end

  assign bus.scl_oe   = scl_q;
  assign bus.sda_oe   = sda_q;
  assign bus.data_out = rx_q;
  assign bus.ack_out  = ack_q;
  assign bus.ready    = ready_q;

endmodule

// File: tb/tb_i2c_bit_engine.sv
// Self-checking bench for i2c_bit_engine: phase-level line model, open-drain
// slave model on SDA, randomized commands and busy-time strobe noise.
module tb_i2c_bit_engine;
  localparam int DW = 2;
  localparam int Q  = 1 << DW;
  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_STOP  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;
  localparam logic [1:0] C_READ  = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic slave_pull = 1'b0;

  i2c_bit_if bus();
  assign bus.sda_i = ~(bus.sda_oe | slave_pull);

  i2c_bit_engine #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  logic       exp_scl = 1'b0;
  logic       exp_sda = 1'b0;
  logic [7:0] exp_dout = 8'h00;
  logic       exp_ack = 1'b0;
  logic [8:0] obs_hi;

  task automatic model_reset();
    exp_scl = 1'b0; exp_sda = 1'b0; exp_dout = 8'h00; exp_ack = 1'b0;
    slave_pull = 1'b0;
  endtask

  // Issue one command and follow it cycle by cycle against the phase model.
  task automatic run_cmd(input logic [1:0] c, input logic [7:0] d, input logic ai,
                         input logic [7:0] sbyte, input logic sack,
                         input bit noise, input int abort_at);
    int n, k, w, b, waited;
    logic lvl;
    logic [7:0] rx;
    waited = 0;
    while (bus.ready !== 1'b1 && waited < 2000) begin
      @(posedge clk); #1; waited++;
    end
    total++;
    if (bus.ready !== 1'b1) begin
      $display("FAIL wait_ready ready=%b want 1", bus.ready);
      bad++;
      return;
    end
    bus.cmd = c; bus.data_in = d; bus.ack_in = ai; bus.stb = 1'b1;
    slave_pull = 1'b0;
    @(posedge clk); #1;
    bus.stb = 1'b0; bus.data_in = 8'($urandom); bus.ack_in = 1'($urandom);
    n = (c[1] ? 36 : 4) * Q;
    rx = exp_dout;
    for (int i = 0; i < n; i++) begin
      k = i / Q; w = i % Q; b = k / 4;
      if (w == 0) begin
        if (!c[1]) begin
          case (k % 4)
            0: exp_sda = (c == C_STOP);
            1: exp_scl = 1'b0;
            2: exp_sda = (c == C_START);
            3: if (c == C_START) exp_scl = 1'b1;
            default: ;
          endcase
        end else begin
          case (k % 4)
            0: begin
              if (b < 8) exp_sda = (c == C_WRITE) ? ~d[7-b] : 1'b0;
              else       exp_sda = (c == C_WRITE) ? 1'b0 : ~ai;
              if (c == C_WRITE) slave_pull = (b == 8) ? ~sack : 1'b0;
              else              slave_pull = (b < 8) ? ~sbyte[7-b] : 1'b0;
            end
            1: exp_scl = 1'b0;
            2: begin
              lvl = ~(exp_sda | slave_pull);
              if (b < 8) rx = {rx[6:0], lvl};
              else if (c == C_WRITE) exp_ack = lvl;
            end
            3: exp_scl = 1'b1;
            default: ;
          endcase
        end
        total++;
        if (bus.ready !== 1'b0) begin
          $display("FAIL busy_ready cyc=%0d ready=%b want 0", cyc, bus.ready); bad++;
        end
      end
      if (w == 0 || w == Q - 1) begin
        total++;
        if (bus.scl_oe !== exp_scl || bus.sda_oe !== exp_sda) begin
          $display("FAIL lines cmd=%0d phase=%0d cyc=%0d scl_oe=%b sda_oe=%b want %b %b",
                   c, k, cyc, bus.scl_oe, bus.sda_oe, exp_scl, exp_sda);
          bad++;
        end
      end
      if (c[1] && (k % 4) == 2 && w == 0) obs_hi[b] = bus.sda_oe;
      if (i == abort_at) begin
        bus.stb = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        total++;
        if (bus.scl_oe !== 1'b0 || bus.sda_oe !== 1'b0 || bus.ready !== 1'b1 ||
            bus.data_out !== 8'h00 || bus.ack_out !== 1'b0) begin
          $display("FAIL abort_reset scl=%b sda=%b ready=%b dout=%h ack=%b want 0 0 1 00 0",
                   bus.scl_oe, bus.sda_oe, bus.ready, bus.data_out, bus.ack_out);
          bad++;
        end
        return;
      end
      if (noise) begin
        bus.stb = 1'($urandom); bus.cmd = 2'($urandom); bus.data_in = 8'($urandom);
      end
      @(posedge clk); #1;
    end
    bus.stb = 1'b0;
    if (c[1]) exp_dout = rx;
    total++;
    if (bus.ready !== 1'b1) begin
      $display("FAIL done_ready cmd=%0d cyc=%0d ready=%b want 1", c, cyc, bus.ready); bad++;
    end
    total++;
    if (bus.data_out !== exp_dout || bus.ack_out !== exp_ack) begin
      $display("FAIL result cmd=%0d dout=%h ack=%b want %h %b",
               c, bus.data_out, bus.ack_out, exp_dout, exp_ack);
      bad++;
    end
    total++;
    if (bus.scl_oe !== exp_scl || bus.sda_oe !== exp_sda) begin
      $display("FAIL end_lines cmd=%0d scl=%b sda=%b want %b %b",
               c, bus.scl_oe, bus.sda_oe, exp_scl, exp_sda);
      bad++;
    end
  endtask

  task automatic test_reset();
    bus.stb = 1'b0; bus.cmd = C_START; bus.data_in = 8'h00; bus.ack_in = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    bus.stb = 1'b1; bus.cmd = C_WRITE;
    @(posedge clk); #1;
    rst = 1'b0; bus.stb = 1'b0;
    model_reset();
    total++;
    if (bus.scl_oe !== 1'b0 || bus.sda_oe !== 1'b0 || bus.ready !== 1'b1 ||
        bus.data_out !== 8'h00 || bus.ack_out !== 1'b0) begin
      $display("FAIL reset scl=%b sda=%b ready=%b dout=%h ack=%b want 0 0 1 00 0",
               bus.scl_oe, bus.sda_oe, bus.ready, bus.data_out, bus.ack_out);
      bad++;
    end
    @(posedge clk); #1;
    total++;
    if (bus.ready !== 1'b1) begin
      $display("FAIL reset_idle ready=%b want 1", bus.ready); bad++;
    end
  endtask

  task automatic test_start();
    run_cmd(C_START, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, -1);
  endtask

  task automatic test_write();
    logic [7:0] hi;
    run_cmd(C_WRITE, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, -1);
    hi = {obs_hi[0], obs_hi[1], obs_hi[2], obs_hi[3],
          obs_hi[4], obs_hi[5], obs_hi[6], obs_hi[7]};
    total++;
    if (hi !== 8'b0101_1010) begin
      $display("FAIL write_sda_seq got=%b want 01011010", hi); bad++;
    end
    total++;
    if (bus.data_out !== 8'hA5 || bus.ack_out !== 1'b0) begin
      $display("FAIL write_a5 dout=%h ack=%b want a5 0", bus.data_out, bus.ack_out); bad++;
    end
  endtask

  task automatic test_read();
    run_cmd(C_READ, 8'hFF, 1'b1, 8'h3C, 1'b0, 1'b0, -1);
    total++;
    if (bus.data_out !== 8'h3C || obs_hi[8] !== 1'b0 || bus.ack_out !== 1'b0) begin
      $display("FAIL read_3c dout=%h nack_sda_oe=%b ack=%b want 3c 0 0",
               bus.data_out, obs_hi[8], bus.ack_out);
      bad++;
    end
  endtask

  task automatic test_back_to_back();
    run_cmd(C_WRITE, 8'($urandom), 1'b0, 8'h00, 1'b1, 1'b1, -1);
    run_cmd(C_STOP, 8'($urandom), 1'b0, 8'h00, 1'b0, 1'b1, -1);
    total++;
    if (bus.scl_oe !== 1'b0 || bus.sda_oe !== 1'b0) begin
      $display("FAIL stop_release scl=%b sda=%b want 0 0", bus.scl_oe, bus.sda_oe); bad++;
    end
  endtask

  task automatic test_random();
    logic [1:0] c;
    int gap;
    for (int r = 0; r < 12; r++) begin
      c = (r == 0) ? C_START : 2'($urandom);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
      run_cmd(c, 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
              1'($urandom), -1);
    end
  endtask

  task automatic test_reset_mid();
    run_cmd(C_START, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, -1);
    run_cmd(C_WRITE, 8'h96, 1'b0, 8'h00, 1'b0, 1'b0, 16 * Q + 5);
    run_cmd(C_START, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, -1);
    total++;
    if (bus.scl_oe !== 1'b1 || bus.sda_oe !== 1'b1) begin
      $display("FAIL start_after_reset scl=%b sda=%b want 1 1", bus.scl_oe, bus.sda_oe); bad++;
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_write();
    test_read();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
